// File: rtl/dip_switch_pkg.sv
// Shared constants for the DIP-switch conditioning path: FSM encoding and default sizes.
package dip_switch_pkg;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SETTLING = 1'b1;

  localparam int SWITCH_WIDTH            = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 10000;

endpackage

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs. Reusable for any pad bus.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/switch_debouncer.sv
// DIP-switch debouncer: 2FF sync, stability timer, registered pattern plus change strobe.
// Build option SWITCH_REVERSE_EN presents sw_stable bit-reversed (pad bit 0 becomes MSB).
module switch_debouncer
  import dip_switch_pkg::*;
#(
  parameter int WIDTH           = SWITCH_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             enable,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             sw_settling
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] accepted_ord;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             changed_q, changed_d;

  sync_2ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sw_in),
    .q_o   (sync2)
  );

  // Reordering happens before storage so the change strobe compares output-ordered values.
`ifdef SWITCH_REVERSE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign accepted_ord[gi] = cand_q[WIDTH-1-gi];
  end
`else
  assign accepted_ord = cand_q;
`endif

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (!enable) begin
      // Candidate keeps following the input so re-enable needs a fresh change to qualify.
      state_d = ST_IDLE;
      cnt_d   = '0;
      cand_d  = sync2;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sync2 != cand_q) begin
            cand_d  = sync2;
            cnt_d   = '0;
            state_d = ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (sync2 != cand_q) begin
            cand_d = sync2;
            cnt_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            stable_d  = accepted_ord;
            changed_d = (accepted_ord != stable_q);
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable   = stable_q;
  assign sw_changed  = changed_q;
  assign sw_settling = (state_q == ST_SETTLING);

endmodule
